// File: rtl/uart_rx_word_packer.sv
`default_nettype none
//============================================================================
// Module   : uart_rx_word_packer
// Purpose  : Packs UART receiver byte strobes MSB-first into words with a
//            valid/ready output, inter-byte timeout and overrun flagging.
// Revision : 1.0 - initial release
//============================================================================
module uart_rx_word_packer #(
    parameter int WORD_BYTES   = 4,
    parameter int TIMEOUT_CLKS = 100000
) (
    input  logic                    i_Clock,
    input  logic                    i_Reset_n,
    input  logic                    i_Rx_DV,
    input  logic [7:0]              i_Rx_Byte,
    output logic [8*WORD_BYTES-1:0] o_Word,
    output logic                    o_Word_Valid,
    input  logic                    i_Word_Ready,
    output logic                    o_Overrun,
    output logic                    o_Timeout,
    output logic                    o_Busy
);

    localparam int c_WORD_W = 8 * WORD_BYTES;
    localparam int c_CNT_W  = $clog2(WORD_BYTES);
    localparam int c_TMO_W  = $clog2(TIMEOUT_CLKS);
    localparam logic [c_CNT_W-1:0] c_LAST_BYTE  = c_CNT_W'(WORD_BYTES - 1);
    localparam logic [c_TMO_W-1:0] c_TMO_EXPIRE = c_TMO_W'(TIMEOUT_CLKS - 1);

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_HOLD    = 2'd1
    } state_t;

    state_t                r_state;
    logic [c_WORD_W-1:0]   r_shift;
    logic [c_CNT_W-1:0]    r_count;
    logic [c_TMO_W-1:0]    r_tmo;

    state_t                w_state_nxt;
    logic [c_WORD_W-1:0]   w_shift_nxt;
    logic [c_CNT_W-1:0]    w_count_nxt;
    logic [c_TMO_W-1:0]    w_tmo_nxt;
    logic [c_TMO_W-1:0]    w_tmo_inc;
    logic [c_WORD_W-1:0]   w_word_nxt;
    logic [c_WORD_W-1:0]   w_shifted;
    logic                  w_valid_nxt;
    logic                  w_ovr_nxt;
    logic                  w_tout_nxt;
    logic                  w_xfer;

    assign w_xfer    = o_Word_Valid & i_Word_Ready;
    assign w_shifted = {r_shift[c_WORD_W-9:0], i_Rx_Byte};
    assign w_tmo_inc = r_tmo + c_TMO_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_count_nxt = r_count;
        w_tmo_nxt   = r_tmo;
        w_word_nxt  = o_Word;
        w_valid_nxt = o_Word_Valid & ~w_xfer;
        w_ovr_nxt   = 1'b0;
        w_tout_nxt  = 1'b0;

        case (r_state)
            S_COLLECT: begin
                if (i_Rx_DV) begin
                    w_shift_nxt = w_shifted;
                    w_tmo_nxt   = '0;
                    if (r_count == c_LAST_BYTE) begin
                        w_count_nxt = '0;
                        if (!o_Word_Valid || w_xfer) begin
                            w_word_nxt  = w_shifted;
                            w_valid_nxt = 1'b1;
                        end else begin
                            // Output still occupied: park the word in the shifter.
                            w_state_nxt = S_HOLD;
                        end
                    end else begin
                        w_count_nxt = r_count + c_CNT_W'(1);
                    end
                end else if (r_count != '0) begin
                    if (w_tmo_inc == c_TMO_EXPIRE) begin
                        w_count_nxt = '0;
                        w_tmo_nxt   = '0;
                        w_tout_nxt  = 1'b1;
                    end else begin
                        w_tmo_nxt = w_tmo_inc;
                    end
                end else begin
                    w_tmo_nxt = '0;
                end
            end
            S_HOLD: begin
                w_tmo_nxt = '0;
                w_ovr_nxt = i_Rx_DV;
                if (w_xfer) begin
                    w_word_nxt  = r_shift;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = S_COLLECT;
                end
            end
            default: begin
                w_state_nxt = S_COLLECT;
                w_count_nxt = '0;
                w_tmo_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            r_state      <= S_COLLECT;
            r_shift      <= '0;
            r_count      <= '0;
            r_tmo        <= '0;
            o_Word       <= '0;
            o_Word_Valid <= 1'b0;
            o_Overrun    <= 1'b0;
            o_Timeout    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_shift      <= w_shift_nxt;
            r_count      <= w_count_nxt;
            r_tmo        <= w_tmo_nxt;
            o_Word       <= w_word_nxt;
            o_Word_Valid <= w_valid_nxt;
            o_Overrun    <= w_ovr_nxt;
            o_Timeout    <= w_tout_nxt;
        end
    end

    assign o_Busy = (r_count != '0) | (r_state == S_HOLD);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_word_packer.sv
`default_nettype none
//============================================================================
// Module   : tb_uart_rx_word_packer
// Purpose  : Self-checking bench for uart_rx_word_packer against a
//            queue-based byte/word reference model.
// Revision : 1.0 - initial release
//============================================================================
module tb_uart_rx_word_packer;

    localparam int WB = 4;
    localparam int T  = 16;

    logic        i_Clock = 1'b0;
    logic        i_Reset_n = 1'b0;
    logic        i_Rx_DV = 1'b0;
    logic [7:0]  i_Rx_Byte = 8'h00;
    logic [31:0] o_Word;
    logic        o_Word_Valid;
    logic        i_Word_Ready = 1'b0;
    logic        o_Overrun;
    logic        o_Timeout;
    logic        o_Busy;

    int n_checks = 0;
    int n_pass   = 0;

    uart_rx_word_packer #(.WORD_BYTES(WB), .TIMEOUT_CLKS(T)) dut (
        .i_Clock      (i_Clock),
        .i_Reset_n    (i_Reset_n),
        .i_Rx_DV      (i_Rx_DV),
        .i_Rx_Byte    (i_Rx_Byte),
        .o_Word       (o_Word),
        .o_Word_Valid (o_Word_Valid),
        .i_Word_Ready (i_Word_Ready),
        .o_Overrun    (o_Overrun),
        .o_Timeout    (o_Timeout),
        .o_Busy       (o_Busy)
    );

    always #5 i_Clock = ~i_Clock;

    // Reference model: bytes of the word being gathered, and up to two finished words
    logic [7:0]  partial[$];
    logic [31:0] words[$];
    int          idle = 0;
    logic        m_ovr = 1'b0;
    logic        m_tmo = 1'b0;

    task automatic model_edge(input logic dv, input logic [7:0] b, input logic rdy, input logic rstn);
        bit          held;
        logic [31:0] w;
        m_ovr = 1'b0;
        m_tmo = 1'b0;
        if (!rstn) begin
            partial.delete();
            words.delete();
            idle = 0;
            return;
        end
        held = (words.size() == 2);
        if (words.size() > 0 && rdy) void'(words.pop_front());
        if (dv) begin
            if (held) begin
                m_ovr = 1'b1;
            end else begin
                partial.push_back(b);
                idle = 0;
                if (partial.size() == WB) begin
                    w = 32'h0;
                    foreach (partial[i]) w = {w[23:0], partial[i]};
                    words.push_back(w);
                    partial.delete();
                end
            end
        end else if (partial.size() > 0) begin
            idle++;
            if (idle == T - 1) begin
                partial.delete();
                idle  = 0;
                m_tmo = 1'b1;
            end
        end
    endtask

    function automatic logic [35:0] model_vec();
        logic v;
        v = (words.size() > 0);
        return {v, m_ovr, m_tmo, (partial.size() > 0) || (words.size() > 1), v ? words[0] : 32'h0};
    endfunction

    function automatic logic [35:0] dut_vec();
        return {o_Word_Valid, o_Overrun, o_Timeout, o_Busy, o_Word_Valid ? o_Word : 32'h0};
    endfunction

    task automatic cycle(input logic dv, input logic [7:0] b, input logic rdy, input logic rstn);
        i_Rx_DV      = dv;
        i_Rx_Byte    = b;
        i_Word_Ready = rdy;
        i_Reset_n    = rstn;
        @(posedge i_Clock);
        model_edge(dv, b, rdy, rstn);
        #1;
    endtask

    task automatic test_reset();
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        n_checks++;
        if ({o_Word, o_Word_Valid, o_Overrun, o_Timeout, o_Busy} !== 36'h0)
            $display("FAIL reset_state: got word=%h v=%b ovr=%b tmo=%b busy=%b want all zero", o_Word, o_Word_Valid, o_Overrun, o_Timeout, o_Busy);
        else n_pass++;
    endtask

    task automatic test_basic();
        logic [7:0] bytes[4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        foreach (bytes[i]) begin
            cycle(1'b1, bytes[i], 1'b1, 1'b1);
            n_checks++;
            if (dut_vec() !== model_vec()) $display("FAIL basic_cycle: got %h want %h", dut_vec(), model_vec());
            else n_pass++;
        end
        n_checks++;
        if (o_Word_Valid !== 1'b1 || o_Word !== 32'hDEADBEEF)
            $display("FAIL basic_word: got v=%b word=%h want v=1 word=deadbeef", o_Word_Valid, o_Word);
        else n_pass++;
        cycle(1'b0, 8'h00, 1'b1, 1'b1);
        n_checks++;
        if (o_Word_Valid !== 1'b0 || o_Busy !== 1'b0)
            $display("FAIL basic_after: got v=%b busy=%b want v=0 busy=0", o_Word_Valid, o_Busy);
        else n_pass++;
    endtask

    task automatic test_hold();
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, 8'(i), 1'b0, 1'b1);
            n_checks++;
            if (dut_vec() !== model_vec()) $display("FAIL hold_cycle: got %h want %h", dut_vec(), model_vec());
            else n_pass++;
        end
        n_checks++;
        if (o_Word !== 32'h01020304 || o_Word_Valid !== 1'b1 || o_Busy !== 1'b1)
            $display("FAIL hold_full: got word=%h v=%b busy=%b want 01020304 v=1 busy=1", o_Word, o_Word_Valid, o_Busy);
        else n_pass++;
        cycle(1'b0, 8'h00, 1'b1, 1'b1);
        n_checks++;
        if (o_Word !== 32'h05060708 || o_Word_Valid !== 1'b1 || o_Busy !== 1'b0)
            $display("FAIL hold_promote: got word=%h v=%b busy=%b want 05060708 v=1 busy=0", o_Word, o_Word_Valid, o_Busy);
        else n_pass++;
        cycle(1'b0, 8'h00, 1'b1, 1'b1);
        n_checks++;
        if (o_Word_Valid !== 1'b0) $display("FAIL hold_drain: got v=%b want v=0", o_Word_Valid);
        else n_pass++;
    endtask

    task automatic test_overrun();
        int          n_ovr = 0;
        logic [31:0] drained[$];
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b1);
            if (o_Overrun) n_ovr++;
            n_checks++;
            if (dut_vec() !== model_vec()) $display("FAIL overrun_cycle: got %h want %h", dut_vec(), model_vec());
            else n_pass++;
        end
        n_checks++;
        if (n_ovr != 4) $display("FAIL overrun_count: got %0d pulses want 4", n_ovr);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            if (o_Word_Valid) drained.push_back(o_Word);
            cycle(1'b0, 8'h00, 1'b1, 1'b1);
        end
        n_checks++;
        if (drained.size() != 2 || drained[0] !== 32'h10111213 || drained[1] !== 32'h14151617)
            $display("FAIL overrun_drain: got %0d words first=%h want 2 words 10111213,14151617", drained.size(), drained.size() > 0 ? drained[0] : 32'h0);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int n_tmo = 0;
        logic [7:0] bytes[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b1, 8'hAA, 1'b1, 1'b1);
        cycle(1'b1, 8'hBB, 1'b1, 1'b1);
        for (int i = 0; i < 15; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b1);
            if (o_Timeout) n_tmo++;
            n_checks++;
            if (dut_vec() !== model_vec()) $display("FAIL timeout_cycle: got %h want %h", dut_vec(), model_vec());
            else n_pass++;
        end
        n_checks++;
        if (n_tmo != 1 || o_Timeout !== 1'b1 || o_Busy !== 1'b0)
            $display("FAIL timeout_pulse: got pulses=%0d last=%b busy=%b want 1 pulse on idle clock 15, busy=0", n_tmo, o_Timeout, o_Busy);
        else n_pass++;
        foreach (bytes[i]) cycle(1'b1, bytes[i], 1'b1, 1'b1);
        n_checks++;
        if (o_Word_Valid !== 1'b1 || o_Word !== 32'h11223344)
            $display("FAIL timeout_clean: got v=%b word=%h want 11223344", o_Word_Valid, o_Word);
        else n_pass++;
    endtask

    task automatic test_timeout_race();
        int n_tmo = 0;
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b1, 8'hAA, 1'b1, 1'b1);
        for (int i = 0; i < 14; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b1);
            if (o_Timeout) n_tmo++;
        end
        cycle(1'b1, 8'hBB, 1'b1, 1'b1);
        if (o_Timeout) n_tmo++;
        n_checks++;
        if (n_tmo != 0 || o_Busy !== 1'b1)
            $display("FAIL race_no_timeout: got pulses=%0d busy=%b want 0 pulses busy=1", n_tmo, o_Busy);
        else n_pass++;
        cycle(1'b1, 8'hCC, 1'b1, 1'b1);
        cycle(1'b1, 8'hDD, 1'b1, 1'b1);
        n_checks++;
        if (o_Word_Valid !== 1'b1 || o_Word !== 32'hAABBCCDD)
            $display("FAIL race_word: got v=%b word=%h want aabbccdd", o_Word_Valid, o_Word);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] bytes[4] = '{8'h55, 8'h66, 8'h77, 8'h88};
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b1, 8'h01, 1'b0, 1'b1);
        cycle(1'b1, 8'h02, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        n_checks++;
        if ({o_Word, o_Word_Valid, o_Overrun, o_Timeout, o_Busy} !== 36'h0)
            $display("FAIL reset_partial: got word=%h v=%b busy=%b want all zero", o_Word, o_Word_Valid, o_Busy);
        else n_pass++;
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0, 1'b1);
        cycle(1'b1, 8'h99, 1'b1, 1'b0);
        n_checks++;
        if ({o_Word, o_Word_Valid, o_Overrun, o_Timeout, o_Busy} !== 36'h0)
            $display("FAIL reset_held: got word=%h v=%b ovr=%b busy=%b want all zero", o_Word, o_Word_Valid, o_Overrun, o_Busy);
        else n_pass++;
        foreach (bytes[i]) cycle(1'b1, bytes[i], 1'b1, 1'b1);
        n_checks++;
        if (o_Word_Valid !== 1'b1 || o_Word !== 32'h55667788)
            $display("FAIL reset_recover: got v=%b word=%h want 55667788", o_Word_Valid, o_Word);
        else n_pass++;
    endtask

    task automatic test_random();
        int dv_mod;
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 4000; i++) begin
            // Alternate dense and sparse byte traffic so both overruns and timeouts occur
            dv_mod = ((i / 250) % 2 == 0) ? 2 : 18;
            cycle(($urandom % dv_mod) == 0, 8'($urandom), ($urandom % 3) == 0, ($urandom % 300) != 0);
            n_checks++;
            if (dut_vec() !== model_vec()) $display("FAIL random_cycle %0d: got %h want %h", i, dut_vec(), model_vec());
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_overrun();
        test_timeout();
        test_timeout_race();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
